// File: rtl/mem_port_arbiter.sv
// Purpose : arbitrates an instruction-fetch port and a load/store port onto one shared memory port (round-robin on contention).
// Latency : request sampled at edge N -> mem_en in cycle N+1 -> done pulse in cycle N+2 (zero-wait memory); next grant at edge N+3.
// Backpressure: requesters hold req until their done pulse; memory stalls via mem_ready, bounded by TIMEOUT wait cycles (then err + done).
//
// Ports:
//   clk, clr                 clock, asynchronous active-low reset
//   if_req/if_addr           fetch request and read address
//   if_done/if_rdata         fetch completion pulse and fetched word (0 on timeout)
//   ls_req/ls_we/ls_addr/ls_wdata  load/store request, write enable, address, write data
//   ls_done/ls_rdata         load/store completion pulse and load data (held across writes, 0 on timeout)
//   asid/mem_asid            address-space ID, captured at grant
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata/mem_ready  shared memory port
//   err/err_src              timeout pulse and timed-out source (0 = fetch, 1 = load/store)
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_rdata,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_done,
    output logic [31:0] ls_rdata,
    input  logic [7:0]  asid,
    output logic [7:0]  mem_asid,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        err,
    output logic        err_src
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t      state, state_d;
    logic        last_gnt, last_gnt_d;     // 1 = load/store won the last grant
    logic [7:0]  wait_cnt, wait_cnt_d;
    logic [7:0]  wait_inc;

    logic        if_done_d, ls_done_d, err_d, err_src_d;
    logic [31:0] if_rdata_d, ls_rdata_d;
    logic        mem_en_d, mem_we_d;
    logic [31:0] mem_addr_d, mem_wdata_d;
    logic [7:0]  mem_asid_d;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state     <= IDLE;
            last_gnt  <= 1'b1;   // first contended grant goes to fetch
            wait_cnt  <= 8'd0;
            if_done   <= 1'b0;
            ls_done   <= 1'b0;
            err       <= 1'b0;
            err_src   <= 1'b0;
            if_rdata  <= 32'h0;
            ls_rdata  <= 32'h0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'h0;
            mem_wdata <= 32'h0;
            mem_asid  <= 8'h0;
        end else begin
            state     <= state_d;
            last_gnt  <= last_gnt_d;
            wait_cnt  <= wait_cnt_d;
            if_done   <= if_done_d;
            ls_done   <= ls_done_d;
            err       <= err_d;
            err_src   <= err_src_d;
            if_rdata  <= if_rdata_d;
            ls_rdata  <= ls_rdata_d;
            mem_en    <= mem_en_d;
            mem_we    <= mem_we_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            mem_asid  <= mem_asid_d;
        end
    end

    always_comb begin
        state_d     = state;
        last_gnt_d  = last_gnt;
        wait_cnt_d  = wait_cnt;
        wait_inc    = wait_cnt + 8'd1;
        if_done_d   = 1'b0;
        ls_done_d   = 1'b0;
        err_d       = 1'b0;
        err_src_d   = err_src;
        if_rdata_d  = if_rdata;
        ls_rdata_d  = ls_rdata;
        mem_en_d    = mem_en;
        mem_we_d    = mem_we;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        mem_asid_d  = mem_asid;

        case (state)
            IDLE: begin
                // Fetch wins when alone, or when contended and ls won last time.
                if (if_req && (!ls_req || last_gnt)) begin
                    state_d     = FETCH;
                    last_gnt_d  = 1'b0;
                    wait_cnt_d  = 8'd0;
                    mem_en_d    = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr;
                    mem_wdata_d = 32'h0;
                    mem_asid_d  = asid;
                end else if (ls_req) begin
                    state_d     = DATA;
                    last_gnt_d  = 1'b1;
                    wait_cnt_d  = 8'd0;
                    mem_en_d    = 1'b1;
                    mem_we_d    = ls_we;
                    mem_addr_d  = ls_addr;
                    mem_wdata_d = ls_wdata;
                    mem_asid_d  = asid;
                end
            end

            FETCH, DATA: begin
                if (mem_en && mem_ready) begin
                    state_d  = RESP;
                    mem_en_d = 1'b0;
                    if (state == FETCH) begin
                        if_done_d  = 1'b1;
                        if_rdata_d = mem_rdata;
                    end else begin
                        ls_done_d = 1'b1;
                        // Stores leave the last load value in place.
                        if (!mem_we) begin
                            ls_rdata_d = mem_rdata;
                        end
                    end
                end else if (wait_inc == TIMEOUT_CNT) begin
                    // mem_en has now been high for TIMEOUT cycles without mem_ready.
                    state_d   = RESP;
                    mem_en_d  = 1'b0;
                    err_d     = 1'b1;
                    err_src_d = (state == DATA);
                    if (state == FETCH) begin
                        if_done_d  = 1'b1;
                        if_rdata_d = 32'h0;
                    end else begin
                        ls_done_d  = 1'b1;
                        ls_rdata_d = 32'h0;
                    end
                end else begin
                    wait_cnt_d = wait_inc;
                end
            end

            RESP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int TO = 15;

    logic        clk;
    logic        clr;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_rdata;
    logic        ls_req;
    logic        ls_we;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic        ls_done;
    logic [31:0] ls_rdata;
    logic [7:0]  asid;
    logic [7:0]  mem_asid;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        err;
    logic        err_src;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: transaction-level view of arbiter state.
    bit          m_last_ls;
    logic [31:0] m_if_rdata;
    logic [31:0] m_ls_rdata;

    mem_port_arbiter #(.TIMEOUT(TO)) dut (
        .clk       (clk),
        .clr       (clr),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_done   (if_done),
        .if_rdata  (if_rdata),
        .ls_req    (ls_req),
        .ls_we     (ls_we),
        .ls_addr   (ls_addr),
        .ls_wdata  (ls_wdata),
        .ls_done   (ls_done),
        .ls_rdata  (ls_rdata),
        .asid      (asid),
        .mem_asid  (mem_asid),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .err       (err),
        .err_src   (err_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string pfx);
        chk({pfx, "_if_done"},   32'(if_done),   32'h0);
        chk({pfx, "_if_rdata"},  if_rdata,       32'h0);
        chk({pfx, "_ls_done"},   32'(ls_done),   32'h0);
        chk({pfx, "_ls_rdata"},  ls_rdata,       32'h0);
        chk({pfx, "_mem_en"},    32'(mem_en),    32'h0);
        chk({pfx, "_mem_we"},    32'(mem_we),    32'h0);
        chk({pfx, "_mem_addr"},  mem_addr,       32'h0);
        chk({pfx, "_mem_wdata"}, mem_wdata,      32'h0);
        chk({pfx, "_mem_asid"},  32'(mem_asid),  32'h0);
        chk({pfx, "_err"},       32'(err),       32'h0);
        chk({pfx, "_err_src"},   32'(err_src),   32'h0);
    endtask

    task automatic model_reset();
        m_last_ls  = 1'b1;
        m_if_rdata = 32'h0;
        m_ls_rdata = 32'h0;
    endtask

    // Called during an IDLE cycle with at least one request raised.
    // delay = wait cycles before mem_ready; delay >= TO means the access times out.
    task automatic run_txn(input int delay, input logic [31:0] rdata, input bit perturb, output bit src);
        logic [31:0] e_addr, e_wdata;
        logic [7:0]  e_asid;
        logic        e_we;
        bit          tmo;

        if (if_req && ls_req) src = m_last_ls ? 1'b0 : 1'b1;
        else                  src = ls_req;
        e_addr  = src ? ls_addr : if_addr;
        e_we    = src ? ls_we : 1'b0;
        e_wdata = ls_wdata;
        e_asid  = asid;
        tmo     = (delay >= TO);
        m_last_ls = src;

        mem_ready = 1'($urandom);   // memory idle: must be ignored
        mem_rdata = $urandom;
        step();

        for (int c = 1; c <= TO; c++) begin
            chk("acc_mem_en",   32'(mem_en),   32'h1);
            chk("acc_mem_addr", mem_addr,      e_addr);
            chk("acc_mem_we",   32'(mem_we),   32'(e_we));
            chk("acc_mem_asid", 32'(mem_asid), 32'(e_asid));
            if (src) chk("acc_mem_wdata", mem_wdata, e_wdata);
            chk("acc_no_done",  32'({if_done, ls_done, err}), 32'h0);
            if (perturb) begin
                if_addr = $urandom;
                asid    = 8'($urandom);
                if (!if_req) if_req = 1'b1;
                if (!ls_req) ls_req = 1'b1;
                ls_addr  = $urandom;
                ls_wdata = $urandom;
                ls_we    = 1'($urandom);
            end
            mem_ready = (c - 1 == delay);
            mem_rdata = (c - 1 == delay) ? rdata : $urandom;
            step();
            if (c - 1 == delay) break;
        end

        if (src == 1'b0) m_if_rdata = tmo ? 32'h0 : rdata;
        else if (tmo)    m_ls_rdata = 32'h0;
        else if (!e_we)  m_ls_rdata = rdata;

        chk("resp_mem_en",  32'(mem_en),  32'h0);
        chk("resp_if_done", 32'(if_done), 32'(!src));
        chk("resp_ls_done", 32'(ls_done), 32'(src));
        chk("resp_err",     32'(err),     32'(tmo));
        if (tmo) chk("resp_err_src", 32'(err_src), 32'(src));
        chk("resp_if_rdata", if_rdata, m_if_rdata);
        chk("resp_ls_rdata", ls_rdata, m_ls_rdata);

        if (src) ls_req = 1'b0;
        else     if_req = 1'b0;
        mem_ready = 1'($urandom);
        step();
        chk("idle_pulse_end", 32'({if_done, ls_done, err}), 32'h0);
        chk("idle_mem_en",    32'(mem_en), 32'h0);
        mem_ready = 1'b0;
    endtask

    initial begin
        bit src;
        int delay;
        int r;

        clr = 1'b0; if_req = 1'b0; if_addr = 32'h0; ls_req = 1'b0; ls_we = 1'b0;
        ls_addr = 32'h0; ls_wdata = 32'h0; asid = 8'h0; mem_rdata = 32'h0; mem_ready = 1'b0;
        model_reset();

        // Reset state
        step(); step();
        chk_all_zero("rst");
        @(negedge clk); clr = 1'b1;
        step();

        // Round-robin with both requests held from reset: fetch, ls, fetch, ls
        if_req = 1'b1; if_addr = 32'h0000_1000;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h0000_2000; ls_wdata = 32'h0;
        asid = 8'h5;
        for (int k = 0; k < 4; k++) begin
            run_txn(k, 32'h1111_0000 + 32'(k), 1'b0, src);
            chk("rr_order", 32'(src), 32'(k % 2));
            if (src) begin ls_req = 1'b1; ls_addr = ls_addr + 32'h4; end
            else     begin if_req = 1'b1; if_addr = if_addr + 32'h4; end
        end
        if_req = 1'b0; ls_req = 1'b0;
        step();

        // Single zero-wait fetch
        if_req = 1'b1; if_addr = 32'h0000_0040; asid = 8'h1;
        run_txn(0, 32'h2402_0005, 1'b0, src);
        chk("fetch_src", 32'(src), 32'h0);
        chk("fetch_rdata", if_rdata, 32'h2402_0005);

        // Load then store: store leaves ls_rdata untouched
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h104; asid = 8'h3;
        run_txn(1, 32'h1234_5678, 1'b0, src);
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h100; ls_wdata = 32'hDEAD_BEEF; asid = 8'h3;
        run_txn(2, 32'hCAFE_F00D, 1'b0, src);
        chk("store_src", 32'(src), 32'h1);
        chk("store_rdata_held", ls_rdata, 32'h1234_5678);

        // Fetch timeout after TO wait cycles
        if_req = 1'b1; if_addr = 32'h0000_0080;
        run_txn(TO + 5, 32'h5555_5555, 1'b0, src);
        chk("tmo_if_rdata", if_rdata, 32'h0);

        // Request changes during FETCH are ignored; ls waits for the RESP cycle
        if_req = 1'b1; if_addr = 32'h0000_00C0;
        run_txn(3, 32'h7777_0001, 1'b1, src);
        chk("hold_src", 32'(src), 32'h0);
        if_req = 1'b0;
        run_txn(0, 32'h7777_0002, 1'b0, src);
        chk("hold_then_ls", 32'(src), 32'h1);

        // Reset asserted mid-DATA
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h300; asid = 8'h9;
        step();
        chk("mid_mem_en", 32'(mem_en), 32'h1);
        step(); step();
        #2 clr = 1'b0;
        #1;
        chk_all_zero("midrst");
        ls_req = 1'b0;
        step();
        chk("midrst_no_done", 32'({ls_done, if_done, err}), 32'h0);
        #3 clr = 1'b1;
        model_reset();
        step();
        if_req = 1'b1; if_addr = 32'h400; ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h500;
        run_txn(1, 32'hABCD_0001, 1'b0, src);
        chk("post_rst_first", 32'(src), 32'h0);
        run_txn(0, 32'hABCD_0002, 1'b0, src);
        chk("post_rst_second", 32'(src), 32'h1);

        // Randomized traffic
        for (int i = 0; i < 200; i++) begin
            if (!if_req && ($urandom_range(0, 2) != 0)) begin
                if_req = 1'b1; if_addr = $urandom;
            end
            if (!ls_req && ($urandom_range(0, 2) != 0)) begin
                ls_req = 1'b1; ls_we = 1'($urandom); ls_addr = $urandom; ls_wdata = $urandom;
            end
            asid = 8'($urandom);
            if (!if_req && !ls_req) begin
                mem_ready = 1'($urandom);
                step();
                chk("rnd_idle_mem_en", 32'(mem_en), 32'h0);
                mem_ready = 1'b0;
                continue;
            end
            r = $urandom_range(0, 9);
            if (r < 6)       delay = $urandom_range(0, 4);
            else if (r == 6) delay = TO - 1;
            else if (r == 7) delay = TO;
            else             delay = $urandom_range(0, TO + 3);
            run_txn(delay, $urandom, 1'($urandom), src);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
